// File: rtl/ascon_job_scheduler.sv
// ascon_job_scheduler: round-robin sequencer that shares one Ascon
// fault-countermeasure core between two requesters. Each job is guarded by a
// watchdog; a hung core is pulsed through core_rst and reported as a timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no job; grant when a request waits and both FC readies are 0
// START   | one cycle: accept pulse on req_ready, start line rises
// WAIT    | start held, watchdog counts up until matching ready or TIMEOUT
// RECOVER | start low, core_rst high for RST_CYC cycles
// RESP    | result presented until resp_valid && resp_ready
module ascon_job_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10,
  parameter int RST_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_op,
  output logic [1:0] req_ready,
  output logic       encryption_start,
  output logic       decryption_start,
  input  logic       encryption_ready,
  input  logic       decryption_ready,
  input  logic       message_authentication,
  output logic       core_rst,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic       resp_op,
  output logic       resp_auth,
  output logic       resp_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [CW-1:0] TC_VAL   = CW'(TIMEOUT);
  localparam logic [CW-1:0] REC_LOAD = CW'(RST_CYC - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          rr;
  logic          job_id, job_op;
  logic          grant_ok, grant_id;
  logic          done, tc, rec_done;
  logic          op_sel, start_d;
  logic [1:0]    req_ready_d;
  logic          enc_start_d, dec_start_d, resp_valid_d, busy_d;

  // Stale ready from the previous job must be gone before a new grant.
  assign grant_ok = (|req_valid) && !encryption_ready && !decryption_ready;
  assign grant_id = (req_valid == 2'b11) ? rr : req_valid[1];
  assign done     = job_op ? decryption_ready : encryption_ready;
  assign tc       = (cnt == TC_VAL);
  assign rec_done = (cnt == '0);

  // Core reset follows rst combinationally so the FC is held during our reset.
  assign core_rst = rst || (state == S_RECOVER);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ready wins over a coincident terminal count.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (grant_ok) state_nxt = S_START;
      S_START:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (done)    state_nxt = S_RESP;
        else if (tc) state_nxt = S_RECOVER;
      end
      S_RECOVER: if (rec_done) state_nxt = S_RESP;
      S_RESP:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    op_sel       = (state == S_IDLE) ? req_op[grant_id] : job_op;
    start_d      = (state_nxt == S_START) || (state_nxt == S_WAIT);
    enc_start_d  = start_d && !op_sel;
    dec_start_d  = start_d && op_sel;
    req_ready_d  = 2'b00;
    if (state == S_IDLE && state_nxt == S_START)
      req_ready_d = grant_id ? 2'b10 : 2'b01;
    resp_valid_d = (state_nxt == S_RESP);
    busy_d       = (state_nxt != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready        <= 2'b00;
      encryption_start <= 1'b0;
      decryption_start <= 1'b0;
      resp_valid       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      req_ready        <= req_ready_d;
      encryption_start <= enc_start_d;
      decryption_start <= dec_start_d;
      resp_valid       <= resp_valid_d;
      busy             <= busy_d;
    end
  end

  // Job context, watchdog / recover counter, round-robin pointer, result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rr           <= 1'b0;
      job_id       <= 1'b0;
      job_op       <= 1'b0;
      resp_id      <= 1'b0;
      resp_op      <= 1'b0;
      resp_auth    <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            job_id <= grant_id;
            job_op <= req_op[grant_id];
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          if (done) begin
            resp_id      <= job_id;
            resp_op      <= job_op;
            resp_auth    <= job_op && message_authentication;
            resp_timeout <= 1'b0;
          end else if (tc) begin
            cnt          <= REC_LOAD;
            resp_id      <= job_id;
            resp_op      <= job_op;
            resp_auth    <= 1'b0;
            resp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RECOVER: if (!rec_done) cnt <= cnt - CW'(1);
        S_RESP:    if (resp_ready) rr <= ~job_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_job_scheduler.sv
// tb_ascon_job_scheduler: directed and randomized jobs against a behavioural
// model (request set, round-robin pointer, per-job cycle arithmetic).
module tb_ascon_job_scheduler;

  localparam int TIMEOUT = 15;
  localparam int CW      = 4;
  localparam int RST_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_op, req_ready;
  logic       encryption_start, decryption_start;
  logic       encryption_ready, decryption_ready, message_authentication;
  logic       core_rst, resp_valid, resp_ready;
  logic       resp_id, resp_op, resp_auth, resp_timeout, busy;

  always #5 clk = ~clk;

  ascon_job_scheduler #(.TIMEOUT(TIMEOUT), .CW(CW), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .encryption_start(encryption_start), .decryption_start(decryption_start),
    .encryption_ready(encryption_ready), .decryption_ready(decryption_ready),
    .message_authentication(message_authentication),
    .core_rst(core_rst),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_op(resp_op), .resp_auth(resp_auth),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model state: pending request set, their ops, round-robin pointer.
  logic       model_rr;
  logic [1:0] pend, pend_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present pending requests; optionally prove a stale ready blocks the grant.
  task automatic grant_phase(input int stale, output logic w, output logic op);
    logic exp_w;
    req_valid = pend;
    req_op    = pend_op;
    if (stale > 0) begin
      for (int i = 0; i < stale; i++) begin
        step();
        chk("stale_ready_blocks_grant", {busy, req_ready}, 3'b000);
      end
      encryption_ready = 1'b0;
      decryption_ready = 1'b0;
    end
    exp_w = (pend == 2'b11) ? model_rr : pend[1];
    w  = exp_w;
    op = pend_op[exp_w];
    step();
    chk("grant_req_ready", req_ready, exp_w ? 2'b10 : 2'b01);
    chk("start_line_at_start", {decryption_start, encryption_start}, op ? 2'b10 : 2'b01);
    chk("busy_in_start", busy, 1'b1);
    pend[exp_w] = 1'b0;
    req_valid   = pend;
  endtask

  // FC model: matching ready rises lat cycles after start (lat<0: never).
  task automatic body_phase(input logic w, input logic op, input int lat, input logic auth,
                            input logic hold, output logic exp_to, output logic exp_auth);
    int k, n_start, n_wrong, n_crst, n_rr, exp_start, exp_resp;
    bit got;
    k = 0; n_start = 1; n_wrong = 0; n_crst = 0; n_rr = 0; got = 0;
    exp_to    = (lat < 0) || (lat > TIMEOUT + 1);
    exp_auth  = !exp_to && op && auth;
    exp_start = exp_to ? TIMEOUT + 2 : lat + 1;
    exp_resp  = exp_to ? TIMEOUT + 2 + RST_CYC : lat + 1;
    while (!got && k < 100) begin
      message_authentication = (k == lat) ? auth : ~auth;
      if (k == lat) begin
        if (op) decryption_ready = 1'b1;
        else    encryption_ready = 1'b1;
      end
      step();
      k++;
      if (resp_valid === 1'b1) got = 1;
      else begin
        if ((op ? decryption_start : encryption_start) === 1'b1) n_start++;
        if ((op ? encryption_start : decryption_start) === 1'b1) n_wrong++;
        if (core_rst === 1'b1) n_crst++;
        if (req_ready !== 2'b00) n_rr++;
      end
    end
    chk("resp_latency", k, exp_resp);
    chk("start_high_cycles", n_start, exp_start);
    chk("wrong_start_cycles", n_wrong, 0);
    chk("core_rst_cycles", n_crst, exp_to ? RST_CYC : 0);
    chk("req_ready_single_pulse", n_rr, 0);
    chk("start_low_in_resp", {decryption_start, encryption_start}, 2'b00);
    if (!hold) begin
      encryption_ready = 1'b0;
      decryption_ready = 1'b0;
    end
    message_authentication = 1'($urandom_range(0, 1));
  endtask

  // Hold off the response d cycles, then handshake and expect IDLE.
  task automatic resp_phase(input logic w, input logic op, input logic to, input logic au,
                            input int d);
    resp_ready = 1'b0;
    chk("resp_fields", {resp_valid, resp_id, resp_op, resp_auth, resp_timeout},
        {1'b1, w, op, au, to});
    for (int i = 0; i < d; i++) begin
      step();
      chk("resp_backpressure_stable",
          {resp_valid, resp_id, resp_op, resp_auth, resp_timeout, busy, req_ready},
          {1'b1, w, op, au, to, 1'b1, 2'b00});
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_drop_after_handshake", {resp_valid, busy}, 2'b00);
    model_rr = ~w;
  endtask

  task automatic run_job(input int stale, input int lat, input logic auth, input logic hold,
                         input int d);
    logic w, op, to, au;
    grant_phase(stale, w, op);
    body_phase(w, op, lat, auth, hold, to, au);
    resp_phase(w, op, to, au, d);
  endtask

  initial begin
    logic       w_dummy, op_dummy;
    logic [1:0] nb;
    int         r, lat;

    rst = 1'b1; req_valid = 2'b00; req_op = 2'b00;
    encryption_ready = 1'b0; decryption_ready = 1'b0;
    message_authentication = 1'b0; resp_ready = 1'b0;
    model_rr = 1'b0; pend = 2'b00; pend_op = 2'b00;

    step(); step();
    chk("reset_outputs", {req_ready, encryption_start, decryption_start, resp_valid,
                          resp_id, resp_op, resp_auth, resp_timeout, busy}, 10'd0);
    chk("core_rst_in_reset", core_rst, 1'b1);
    rst = 1'b0;
    #1;
    chk("core_rst_after_release", core_rst, 1'b0);

    // Both encrypt requests from reset: requester 0 first, 20-cycle FC latency.
    pend = 2'b11; pend_op = 2'b00;
    run_job(0, 20, 1'b1, 1'b0, 0);
    run_job(0, 5, 1'b0, 1'b0, 0);

    // Both decrypt: rr returned to 0, so requester 0 wins again.
    pend = 2'b11; pend_op = 2'b11;
    run_job(0, 7, 1'b1, 1'b0, 0);
    run_job(0, 4, 1'b0, 1'b0, 1);

    // Watchdog timeout on encrypt, then ready on the terminal-count cycle.
    pend = 2'b01; pend_op = 2'b00;
    run_job(0, -1, 1'b1, 1'b0, 0);
    pend = 2'b10; pend_op = 2'b10;
    run_job(0, TIMEOUT + 1, 1'b1, 1'b0, 0);

    // Stale encryption_ready held after a job, then 10-cycle backpressure.
    pend = 2'b01; pend_op = 2'b00;
    run_job(0, 3, 1'b0, 1'b1, 0);
    pend = 2'b10; pend_op = 2'b10;
    run_job(5, 6, 1'b1, 1'b0, 10);

    // Requester 0 job leaves rr=1; then abort a job with reset.
    pend = 2'b01; pend_op = 2'b00;
    run_job(0, 2, 1'b0, 1'b0, 0);
    pend = 2'b10; pend_op = 2'b10;
    grant_phase(0, w_dummy, op_dummy);
    repeat (5) step();
    pend = 2'b11; pend_op = 2'b00;
    req_valid = pend; req_op = pend_op;
    rst = 1'b1;
    #1;
    chk("reset_midjob_outputs", {encryption_start, decryption_start, busy, resp_valid, req_ready},
        6'd0);
    chk("reset_midjob_core_rst", core_rst, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", {core_rst, resp_valid, busy, encryption_start, decryption_start}, 5'b10000);
    end
    rst = 1'b0;
    model_rr = 1'b0;
    #1;
    chk("core_rst_after_midjob_reset", core_rst, 1'b0);
    run_job(0, 8, 1'b0, 1'b0, 0);

    // Randomized jobs; requests stay pending until accepted.
    for (int j = 0; j < 30; j++) begin
      nb = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        if (nb[i] && !pend[i]) begin
          pend[i]    = 1'b1;
          pend_op[i] = 1'($urandom_range(0, 1));
        end
      end
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = -1;
      else if (r == 1) lat = TIMEOUT + 1;
      else if (r == 2) lat = TIMEOUT + 2;
      else             lat = int'($urandom_range(1, 12));
      run_job(0, lat, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ascon_job_scheduler.md
Name: ascon_job_scheduler

Overview:
- Sequences the shared Ascon fault-countermeasure core (FC) between two requesters, e.g. a host-side encrypt path and a decrypt path.
- Arbitrates requests round-robin and drives encryption_start/decryption_start.
- Waits for the matching ready and captures the authentication result.
- Guards every job with a watchdog; a hung core is recovered through a core reset and reported as a timeout.

Parameters:
- TIMEOUT, 1023: max cycles in WAIT before the job is aborted; must be ≤ 2^CW−1.
- CW, 10: watchdog counter width.
- RST_CYC, 2: core_rst pulse length in RECOVER, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester job request, held until accepted
- req_op  in  2  per-requester op, bit i for requester i: 0=encrypt, 1=decrypt
- req_ready  out  2  one-hot accept pulse (one cycle)
- encryption_start  out  1  to FC
- decryption_start  out  1  to FC
- encryption_ready  in  1  from FC
- decryption_ready  in  1  from FC
- message_authentication  in  1  from FC
- core_rst  out  1  reset to FC
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_id  out  1  requester index of the result
- resp_op  out  1  op of the result
- resp_auth  out  1  message_authentication sampled at decryption done; 0 for encrypt
- resp_timeout  out  1  job aborted by watchdog
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State goes to IDLE and rr pointer to 0.
  - All registered outputs are 0.
  - core_rst = rst OR (state==RECOVER), so it is 1 while rst is high.
  - Reset mid-job drops the job silently: no response, start lines low immediately.
- States: IDLE, START, WAIT, RECOVER, RESP. All outputs except core_rst are registered from state/flags.
- IDLE, grant:
  - Grant only when at least one req_valid is set and both encryption_ready and decryption_ready are 0. This blocks stale ready from the previous job.
  - If both requesters are valid, requester rr wins; otherwise the single valid one wins.
  - Latch id=g and op=req_op[g], then go to START.
- START (1 cycle):
  - req_ready[g]=1.
  - Start line for op (encryption_start or decryption_start) goes high.
  - Watchdog count is cleared to 0.
  - Go to WAIT.
- WAIT:
  - The start line stays high, held as a level, and count increments each cycle.
  - Done condition: the ready matching op is 1 (encryption_ready for op=0, decryption_ready for op=1).
  - On done: sample message_authentication (decrypt only), drop the start line, set timeout flag=0, go to RESP.
  - The non-matching ready is ignored.
  - If count==TIMEOUT and ready is not seen: go to RECOVER.
  - If ready and terminal count coincide, ready wins and the job is a normal completion.
- RECOVER:
  - Start line low and core_rst high for exactly RST_CYC cycles.
  - Set timeout flag=1 and auth=0, then go to RESP.
- RESP:
  - resp_valid=1 with resp_id/op/auth/timeout stable until resp_valid && resp_ready.
  - On the handshake cycle: rr <= ~id, go to IDLE, resp_valid drops next cycle.
  - Requests arriving while not in IDLE wait; there is no queueing beyond the held req_valid.
- Latency:
  - Grant at cycle N, start high at N+1.
  - With ready sampled at cycle M, resp_valid is high at M+1.
  - Best-case back-to-back spacing: IDLE→START→WAIT(ready)→RESP→IDLE.
- Start lines are never both high.
- busy=1 in every state except IDLE.

Test Plan:
- Encrypt, normal completion:
  - Stimulus: req_valid=01, req_op=00; FC model raises encryption_ready 20 cycles after start.
  - Response: req_ready=01 for 1 cycle; encryption_start high for 21 cycles, low after ready.
  - Result: resp_valid with id=0, op=0, auth=0, timeout=0.
- Simultaneous requests and round-robin:
  - Stimulus: req_valid=11 from reset.
  - Response: requester 0 is granted first; after its response handshake requester 1 is granted.
  - Then re-assert both: requester 0 is granted again (rr toggles to ~last id).
- Decrypt with authentication:
  - Stimulus: op=1; decryption_ready=1 with message_authentication=1.
  - Response: resp_auth=1. Repeat with message_authentication=0: resp_auth=0.
- Watchdog timeout, ready-wins tie and stale-ready block:
  - Timeout: FC never raises ready, TIMEOUT=15. Start held; core_rst high exactly 2 cycles; resp_timeout=1, auth=0; decryption_start never asserted.
  - Tie: ready on the cycle count==TIMEOUT gives timeout=0.
  - Stale ready: encryption_ready held at 1 after the job and a new req_valid waiting. No grant until ready returns to 0.
- Backpressure and reset mid-job:
  - resp_ready=0 for 10 cycles: resp fields stable, no new grant.
  - rst asserted during WAIT: start lines and busy go 0 immediately, core_rst=1 while rst is high, no response emitted.
  - After rst release, a pending request is granted to requester 0.
